// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: each cycle grants up to N_LANE valid requesters in
// round-robin scan order and broadcasts their payloads on registered lanes.
module cdb_arbiter #(
  parameter int N_REQ     = 4,
  parameter int N_LANE    = 2,
  parameter int PAYLOAD_W = 48
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*PAYLOAD_W-1:0]  req_payload,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_LANE-1:0]           cdb_valid,
  output logic [N_LANE*PAYLOAD_W-1:0] cdb_payload,
  output logic [N_REQ*16-1:0]         grant_cnt,
  output logic [15:0]                 conflict_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     last_grant;
  logic [N_REQ-1:0]     grant;
  logic [N_LANE-1:0]    lane_hit;
  logic [PTR_W-1:0]     lane_sel [N_LANE];
  logic [PAYLOAD_W-1:0] req_pl   [N_REQ];
  logic [15:0]          gcnt     [N_REQ];
  int                   n_valid;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_pl[i] = req_payload[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  // Scan from rr_ptr around the ring; the k-th hit takes lane k.
  always_comb begin
    int idx;
    int n_grant;
    grant      = '0;
    lane_hit   = '0;
    last_grant = '0;
    n_grant    = 0;
    for (int l = 0; l < N_LANE; l++) begin
      lane_sel[l] = '0;
    end
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (i == idx && req_valid[i] && n_grant < N_LANE && !flush && !rst) begin
          grant[i] = 1'b1;
          for (int l = 0; l < N_LANE; l++) begin
            if (l == n_grant) begin
              lane_sel[l] = PTR_W'(i);
              lane_hit[l] = 1'b1;
            end
          end
          last_grant = PTR_W'(i);
          n_grant    = n_grant + 1;
        end
      end
    end
  end

  assign req_ready = grant;
  assign n_valid   = $countones(req_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid    <= '0;
      cdb_payload  <= '0;
      rr_ptr       <= '0;
      conflict_cnt <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        gcnt[i] <= '0;
      end
    end else begin
      cdb_valid <= lane_hit;
      // Idle lanes keep their last payload; only cdb_valid drops.
      for (int l = 0; l < N_LANE; l++) begin
        if (lane_hit[l]) cdb_payload[l*PAYLOAD_W +: PAYLOAD_W] <= req_pl[lane_sel[l]];
      end
      if (|grant) begin
        rr_ptr <= (last_grant == PTR_W'(N_REQ-1)) ? '0 : last_grant + 1'b1;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && gcnt[i] != 16'hFFFF) gcnt[i] <= gcnt[i] + 16'd1;
      end
      if (!flush && n_valid > N_LANE && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_out
    assign grant_cnt[g*16 +: 16] = gcnt[g];
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, sustained-grant saturation,
// and random traffic compared against a queue-based round-robin model.
module tb_cdb_arbiter;
  localparam int NR = 4;
  localparam int NL = 2;
  localparam int PW = 48;

  logic             clk = 1'b0;
  logic             rst, flush;
  logic [NR-1:0]    req_valid;
  logic [NR*PW-1:0] req_payload;
  logic [NR-1:0]    req_ready;
  logic [NL-1:0]    cdb_valid;
  logic [NL*PW-1:0] cdb_payload;
  logic [NR*16-1:0] grant_cnt;
  logic [15:0]      conflict_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_rr = 0;
  logic [NL-1:0] m_valid = '0;
  logic [PW-1:0] m_pl [NL];
  int          m_cnt [NR];
  int          m_conf = 0;

  cdb_arbiter #(.N_REQ(NR), .N_LANE(NL), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid),
    .req_payload(req_payload), .req_ready(req_ready), .cdb_valid(cdb_valid),
    .cdb_payload(cdb_payload), .grant_cnt(grant_cnt), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive, check grants, clock, update model, check registered outputs.
  task automatic step(input logic [NR-1:0] v, input logic f, input logic r,
                      output logic [NR-1:0] ready_seen);
    logic [NR-1:0] er;
    logic [PW-1:0] pl [NR];
    int q[$];
    int idx;
    req_valid = v;
    flush     = f;
    rst       = r;
    for (int i = 0; i < NR; i++) begin
      pl[i] = {$urandom, $urandom};
      req_payload[i*PW +: PW] = pl[i];
    end
    er = '0;
    if (!r && !f) begin
      for (int j = 0; j < NR; j++) begin
        idx = (m_rr + j) % NR;
        if (v[idx] && q.size() < NL) q.push_back(idx);
      end
    end
    foreach (q[k]) er[q[k]] = 1'b1;
    #1;
    ready_seen = req_ready;
    chk("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    #1;
    if (r) begin
      m_rr = 0; m_valid = '0; m_conf = 0;
      for (int l = 0; l < NL; l++) m_pl[l] = '0;
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    end else begin
      for (int l = 0; l < NL; l++) begin
        m_valid[l] = (l < q.size());
        if (l < q.size()) m_pl[l] = pl[q[l]];
      end
      if (q.size() > 0) m_rr = (q[q.size()-1] + 1) % NR;
      foreach (q[k]) if (m_cnt[q[k]] < 65535) m_cnt[q[k]]++;
      if (!f && $countones(v) > NL && m_conf < 65535) m_conf++;
    end
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    for (int l = 0; l < NL; l++) chk("cdb_payload", 64'(cdb_payload[l*PW +: PW]), 64'(m_pl[l]));
    for (int i = 0; i < NR; i++) chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_conf));
  endtask

  typedef struct {
    logic [NR-1:0] v;
    logic          f;
    logic          r;
    logic [NR-1:0] exp_ready;
    logic [NL-1:0] exp_cdb_valid;
  } vec_t;

  initial begin
    vec_t tbl [10];
    logic [NR-1:0] rdy;
    logic [NR-1:0] pend;
    int age [NR];
    logic [NR-1:0] v;
    logic f, r;

    for (int l = 0; l < NL; l++) m_pl[l] = '0;
    for (int i = 0; i < NR; i++) begin m_cnt[i] = 0; age[i] = 0; end
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_payload = '0;

    // reset with everyone requesting: no grants, outputs cleared
    step(4'b1111, 1'b0, 1'b1, rdy);
    chk("reset_ready", 64'(rdy), 64'h0);
    chk("reset_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("reset_payload", 64'(cdb_payload[63:0]), 64'h0);
    chk("reset_grant_cnt", grant_cnt, 64'h0);
    chk("reset_conflict", 64'(conflict_cnt), 64'h0);

    tbl[0] = '{4'b1111, 1'b0, 1'b0, 4'b0011, 2'b11};
    tbl[1] = '{4'b1111, 1'b0, 1'b0, 4'b1100, 2'b11};
    tbl[2] = '{4'b1111, 1'b0, 1'b0, 4'b0011, 2'b11};
    tbl[3] = '{4'b1111, 1'b0, 1'b0, 4'b1100, 2'b11};
    tbl[4] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 2'b01};
    tbl[5] = '{4'b1001, 1'b0, 1'b0, 4'b1001, 2'b11};
    tbl[6] = '{4'b0101, 1'b1, 1'b0, 4'b0000, 2'b00};
    tbl[7] = '{4'b0101, 1'b0, 1'b0, 4'b0101, 2'b11};
    tbl[8] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00};
    tbl[9] = '{4'b1000, 1'b1, 1'b1, 4'b0000, 2'b00};
    for (int t = 0; t < 10; t++) begin
      step(tbl[t].v, tbl[t].f, tbl[t].r, rdy);
      chk("tbl_ready", 64'(rdy), 64'(tbl[t].exp_ready));
      chk("tbl_cdb_valid", 64'(cdb_valid), 64'(tbl[t].exp_cdb_valid));
      if (t == 3) begin
        chk("contention_grant_cnt", grant_cnt, 64'h0002_0002_0002_0002);
        chk("contention_conflict", 64'(conflict_cnt), 64'd4);
      end
    end

    // random traffic; a requester keeps req_valid until granted
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      f = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NR; i++) v[i] = pend[i] ? 1'b1 : ($urandom_range(0, 1) == 1);
      step(v, f, r, rdy);
      for (int i = 0; i < NR; i++) begin
        pend[i] = v[i] && !rdy[i] && !f && !r;
        age[i]  = pend[i] ? age[i] + 1 : 0;
        if (pend[i]) chk("starvation_bound", 64'(age[i] <= 1), 64'h1);
      end
    end

    // saturation of grant_cnt[0], then reset clears everything
    step(4'b0000, 1'b0, 1'b1, rdy);
    for (int c = 0; c < 65537; c++) step(4'b0001, 1'b0, 1'b0, rdy);
    chk("grant_cnt0_saturated", 64'(grant_cnt[15:0]), 64'hFFFF);
    step(4'b0001, 1'b0, 1'b1, rdy);
    chk("rst_ready", 64'(rdy), 64'h0);
    chk("rst_grant_cnt", grant_cnt, 64'h0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst_conflict", 64'(conflict_cnt), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
